// File: rtl/gameover_draw.sv
`default_nettype none
// ============================================================================
// Module      : gameover_draw
// Description : Game-over banner overlay. A small FSM arms on a game_over
//               pulse, shows a blinking player or draw banner from external
//               ROMs, and clears on restart at the next frame start. The
//               video path is a 3-stage pipeline. The address stage is
//               followed by a ROM-wait stage and then by a registered mix.
// Revision    : 1.0 - initial release
// ============================================================================
module gameover_draw #(
  parameter int unsigned PX        = 300,
  parameter int unsigned PY        = 283,
  parameter int unsigned DX        = 300,
  parameter int unsigned DY        = 272,
  parameter logic [11:0] KEY       = 12'hF0F,
  parameter int unsigned BLINK_BIT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        game_over,
  input  logic [1:0]  winner,
  input  logic        restart,
  output logic [12:0] addr_p1,
  output logic [12:0] addr_p2,
  output logic [13:0] addr_dr,
  input  logic [11:0] rgb_p1,
  input  logic [11:0] rgb_p2,
  input  logic [11:0] rgb_draw,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        showing
);

  localparam int unsigned PW = 200;
  localparam int unsigned PH = 34;
  localparam int unsigned DW = 201;
  localparam int unsigned DH = 56;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  // Packed video word: {h[37:27], v[26:16], hs, vs, hb, vb, rgb[11:0]}
  localparam int unsigned VW = 38;

  logic [1:0]    state_q, state_d;
  logic [1:0]    win_q, win_d;
  logic          pending_q, pending_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          showing_q, showing_d;

  logic [12:0]   addr_p_q, addr_p_d;
  logic [13:0]   addr_d_q, addr_d_d;
  logic          in_p1_q, in_p1_d, in_d1_q, in_d1_d;
  logic          in_p2_q, in_d2_q;
  logic [VW-1:0] vid_in, vid1_q, vid2_q, vid3_q, vid3_d;

  logic          fs;
  logic [31:0]   h32, v32;
  logic          hit, banner_on;
  logic [11:0]   pix;

  assign fs     = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign h32    = {21'd0, hcount_in};
  assign v32    = {21'd0, vcount_in};
  assign vid_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

  // FSM state register plus the control registers that move with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      win_q       <= 2'b00;
      pending_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      showing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      showing_q   <= showing_d;
    end
  end

  // Next-state logic; restart dominates game_over, and a pending restart
  // takes effect only at a frame start so the current frame completes
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (game_over && !restart && (winner != 2'b00)) begin
          state_d = S_ARMED;
          win_d   = winner;
        end
      end
      S_ARMED, S_SHOW: begin
        if (fs && pending_q) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
          win_d     = 2'b00;
        end else begin
          if (restart) pending_d = 1'b1;
          if (fs) begin
            if (state_q == S_ARMED) begin
              state_d     = S_SHOW;
              frame_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output: showing follows the registered SHOW state on the same edge
  always_comb begin
    showing_d = (state_d == S_SHOW);
  end

  // Stage 1 combinational: window flags and ROM addresses (zero outside)
  always_comb begin
    in_p1_d  = (h32 >= PX) && (h32 < PX + PW) && (v32 >= PY) && (v32 < PY + PH);
    in_d1_d  = (h32 >= DX) && (h32 < DX + DW) && (v32 >= DY) && (v32 < DY + DH);
    addr_p_d = in_p1_d ? 13'((v32 - PY) * PW + (h32 - PX)) : 13'd0;
    addr_d_d = in_d1_d ? 14'((v32 - DY) * DW + (h32 - DX)) : 14'd0;
  end

  // Stage 3 combinational: pick the ROM pixel for the latched winner
  always_comb begin
    hit = 1'b0;
    pix = 12'd0;
    case (win_q)
      2'b01: begin hit = in_p2_q; pix = rgb_p1;   end
      2'b10: begin hit = in_p2_q; pix = rgb_p2;   end
      2'b11: begin hit = in_d2_q; pix = rgb_draw; end
      default: begin hit = 1'b0; pix = 12'd0;     end
    endcase
    banner_on = (state_q == S_SHOW) && !frame_cnt_q[BLINK_BIT] && hit && (pix != KEY);
    vid3_d = vid2_q;
    if (banner_on) vid3_d[11:0] = pix;
  end

  // Three-stage video pipeline; timing bits are only ever delayed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p_q <= 13'd0;
      addr_d_q <= 14'd0;
      in_p1_q  <= 1'b0;
      in_d1_q  <= 1'b0;
      in_p2_q  <= 1'b0;
      in_d2_q  <= 1'b0;
      vid1_q   <= '0;
      vid2_q   <= '0;
      vid3_q   <= '0;
    end else begin
      addr_p_q <= addr_p_d;
      addr_d_q <= addr_d_d;
      in_p1_q  <= in_p1_d;
      in_d1_q  <= in_d1_d;
      in_p2_q  <= in_p1_q;
      in_d2_q  <= in_d1_q;
      vid1_q   <= vid_in;
      vid2_q   <= vid1_q;
      vid3_q   <= vid3_d;
    end
  end

  assign addr_p1    = addr_p_q;
  assign addr_p2    = addr_p_q;
  assign addr_dr    = addr_d_q;
  assign hcount_out = vid3_q[37:27];
  assign vcount_out = vid3_q[26:16];
  assign hsync_out  = vid3_q[15];
  assign vsync_out  = vid3_q[14];
  assign hblnk_out  = vid3_q[13];
  assign vblnk_out  = vid3_q[12];
  assign rgb_out    = vid3_q[11:0];
  assign showing    = showing_q;

endmodule
`default_nettype wire

// File: tb/tb_gameover_draw.sv
`default_nettype none
// ============================================================================
// Module      : tb_gameover_draw
// Description : Self-checking bench for gameover_draw. Expected outputs are
//               queued with their due cycle when a pixel is driven and are
//               compared by a monitor when that cycle arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gameover_draw;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        game_over, restart;
  logic [1:0]  winner;
  logic [12:0] addr_p1, addr_p2;
  logic [13:0] addr_dr;
  logic [11:0] rgb_p1, rgb_p2, rgb_draw;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        showing;

  gameover_draw dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .game_over(game_over), .winner(winner), .restart(restart),
    .addr_p1(addr_p1), .addr_p2(addr_p2), .addr_dr(addr_dr),
    .rgb_p1(rgb_p1), .rgb_p2(rgb_p2), .rgb_draw(rgb_draw),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .showing(showing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: addr 0 of P1 is 12'hABC, draw addr 11255 holds the key
  function automatic logic [11:0] rom_p1_f(input logic [12:0] a);
    return (a == 13'd0) ? 12'hABC : {1'b0, a[10:0]};
  endfunction
  function automatic logic [11:0] rom_p2_f(input logic [12:0] a);
    return (a == 13'd0) ? 12'h5A5 : {1'b0, ~a[10:0]};
  endfunction
  function automatic logic [11:0] rom_dr_f(input logic [13:0] a);
    return (a == 14'd11255) ? 12'hF0F : {1'b0, a[10:0]};
  endfunction

  // Synchronous ROM models: data one clock after the address
  always @(posedge clk) begin
    rgb_p1   <= rom_p1_f(addr_p1);
    rgb_p2   <= rom_p2_f(addr_p2);
    rgb_draw <= rom_dr_f(addr_dr);
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          kind;   // 0 = video out, 1 = addresses + showing
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];

  // Monitor: sample #1 after each rising edge and retire due expectations
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < sb.size(); ) begin
      if (sb[i].due == cyc) begin
        if (sb[i].kind == 0) begin
          check({sb[i].tag, ".rgb"}, {20'd0, rgb_out}, sb[i].a);
          check({sb[i].tag, ".vid"}, {6'd0, hcount_out, vcount_out, hsync_out, vsync_out,
                                      hblnk_out, vblnk_out}, sb[i].b);
        end else begin
          check({sb[i].tag, ".addr_p1"}, {19'd0, addr_p1}, sb[i].a);
          check({sb[i].tag, ".addr_p2"}, {19'd0, addr_p2}, sb[i].a);
          check({sb[i].tag, ".addr_dr"}, {18'd0, addr_dr}, sb[i].b);
          check({sb[i].tag, ".showing"}, {31'd0, showing}, sb[i].c);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // Reference behaviour model, advanced once per driven pixel
  int       mstate = 0;   // 0 idle, 1 armed, 2 show
  int       mwin   = 0;
  int       mpend  = 0;
  int       mfc    = 0;

  task automatic model_step(input logic go, input logic [1:0] w, input logic rs, input logic fs);
    if (mstate == 0) begin
      if (go && !rs && w != 2'b00) begin
        mstate = 1;
        mwin   = int'(w);
      end
    end else if (fs && mpend != 0) begin
      mstate = 0; mpend = 0; mwin = 0;
    end else begin
      if (rs) mpend = 1;
      if (fs) begin
        if (mstate == 1) begin mstate = 2; mfc = 0; end
        else mfc = (mfc + 1) % 256;
      end
    end
  endtask

  task automatic drive(input string tag, input int h, input int v, input logic [11:0] bg,
                       input logic go, input logic [1:0] w, input logic rs, input bit chk);
    logic [10:0] hv, vv;
    logic        fs, ip, id, hit, vis;
    int          ap, ad;
    logic [11:0] pix;
    exp_t        e;
    @(negedge clk);
    hv = 11'(h);
    vv = 11'(v);
    hcount_in = hv;  vcount_in = vv;
    hsync_in  = hv[0];
    vsync_in  = vv[0] ^ hv[1];
    hblnk_in  = hv[2];
    vblnk_in  = vv[2];
    rgb_in    = bg;
    game_over = go;  winner = w;  restart = rs;
    fs = (h == 0) && (v == 0);
    model_step(go, w, rs, fs);
    if (chk) begin
      ip = (h >= 300) && (h < 500) && (v >= 283) && (v < 317);
      id = (h >= 300) && (h < 501) && (v >= 272) && (v < 328);
      ap = ip ? (v - 283) * 200 + (h - 300) : 0;
      ad = id ? (v - 272) * 201 + (h - 300) : 0;
      hit = 1'b0; pix = 12'd0;
      if (mwin == 1) begin hit = ip; pix = rom_p1_f(13'(ap)); end
      if (mwin == 2) begin hit = ip; pix = rom_p2_f(13'(ap)); end
      if (mwin == 3) begin hit = id; pix = rom_dr_f(14'(ad)); end
      vis = (mstate == 2) && ((mfc & 32) == 0) && hit && (pix != 12'hF0F);
      e.tag = tag; e.kind = 1; e.due = cyc + 1;
      e.a = ap; e.b = ad; e.c = (mstate == 2) ? 1 : 0;
      sb.push_back(e);
      e.kind = 0; e.due = cyc + 3;
      e.a = {20'd0, vis ? pix : bg};
      e.b = {6'd0, hv, vv, hsync_in, vsync_in, hblnk_in, vblnk_in};
      e.c = 0;
      sb.push_back(e);
    end
  endtask

  // Checked pixel followed by a quiet filler so the state is stable at mix time
  task automatic pix_chk(input string tag, input int h, input int v);
    drive(tag, h, v, 12'h800 | 12'($urandom_range(0, 2047)), 1'b0, 2'b00, 1'b0, 1'b1);
    drive("fill", 1000, 700, 12'h777, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) drive("fill", 1000, 700, 12'h777, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic ctl(input logic go, input logic [1:0] w, input logic rs);
    drive("ctl", 900, 650, 12'h777, go, w, rs, 1'b0);
    fill(1);
  endtask

  task automatic frame_start(input string tag);
    drive(tag, 0, 0, 12'h8AA, 1'b0, 2'b00, 1'b0, 1'b1);
    fill(1);
  endtask

  initial begin
    rst_n = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = '0; game_over = 0; winner = '0; restart = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst.rgb_out", {20'd0, rgb_out}, 32'd0);
    check("rst.showing", {31'd0, showing}, 32'd0);
    check("rst.addr_p1", {19'd0, addr_p1}, 32'd0);
    check("rst.addr_dr", {18'd0, addr_dr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // a) pass-through in IDLE
    drive("a.pass", 10, 10, 12'h123, 1'b0, 2'b00, 1'b0, 1'b1);
    fill(4);

    // b) winner P1
    frame_start("b.fs0");
    pix_chk("b.mid", 50, 50);
    ctl(1'b1, 2'b01, 1'b0);
    pix_chk("b.armed", 300, 283);
    frame_start("b.fs1");
    pix_chk("b.p1_org", 300, 283);
    pix_chk("b.p1_end", 499, 316);
    pix_chk("b.p1_out", 500, 316);
    ctl(1'b1, 2'b10, 1'b0);          // ignored mid-display
    pix_chk("b.p1_keep", 310, 290);
    ctl(1'b0, 2'b00, 1'b1);
    frame_start("b.fs2");
    pix_chk("b.idle", 300, 283);

    // a zero winner is ignored
    ctl(1'b1, 2'b00, 1'b0);
    frame_start("z.fs");
    pix_chk("z.idle", 300, 283);

    // c) draw plus key
    ctl(1'b1, 2'b11, 1'b0);
    frame_start("c.fs");
    pix_chk("c.key", 500, 327);
    pix_chk("c.out", 299, 272);
    pix_chk("c.org", 300, 272);
    pix_chk("c.in", 400, 300);

    // d) blink over 64 frames
    for (int f = 1; f <= 64; f++) begin
      frame_start("d.fs");
      pix_chk($sformatf("d.f%0d", f), 400, 300);
    end
    ctl(1'b0, 2'b00, 1'b1);
    frame_start("d.end");
    pix_chk("d.idle", 400, 300);

    // e) simultaneous game_over and restart in IDLE, then restart in SHOW
    ctl(1'b1, 2'b01, 1'b1);
    frame_start("e.fs0");
    pix_chk("e.idle", 300, 283);
    ctl(1'b1, 2'b10, 1'b0);
    frame_start("e.fs1");
    pix_chk("e.p2a", 350, 290);
    drive("e.rs", 360, 290, 12'h9C3, 1'b0, 2'b00, 1'b1, 1'b1);
    fill(1);
    pix_chk("e.p2b", 370, 290);
    frame_start("e.fs2");
    pix_chk("e.gone", 350, 290);

    // f) asynchronous reset mid-banner
    ctl(1'b1, 2'b01, 1'b0);
    frame_start("f.fs");
    pix_chk("f.on", 310, 290);
    drive("f.hold", 310, 290, 12'h9A1, 1'b0, 2'b00, 1'b0, 1'b0);
    drive("f.hold", 310, 290, 12'h9A1, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    sb.delete();
    mstate = 0; mwin = 0; mpend = 0; mfc = 0;
    rst_n = 1'b0;
    #1;
    check("f.rgb_async", {20'd0, rgb_out}, 32'd0);
    check("f.show_async", {31'd0, showing}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    pix_chk("f.after", 310, 290);
    frame_start("f.fs2");
    pix_chk("f.after2", 310, 290);

    fill(6);
    check("sb.drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gameover_draw.md
GAMEOVER_DRAW -- requirements
Module: gameover_draw

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  PX 300: left x of player1/player2 banner (200x34).
  PY 283: top y of player banner.
  DX 300: left x of draw banner (201x56).
  DY 272: top y of draw banner.
  KEY 12'hF0F: transparent colour; ROM pixels equal to KEY are not drawn.
  BLINK_BIT 5: frame-counter bit gating visibility; the banner is visible while the bit is 0.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  pixel clock; the only clock.
  rst_n  in  1  asynchronous, active-low reset.
  hcount_in  in  11  pixel x.
  vcount_in  in  11  pixel y.
  hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing signals.
  rgb_in  in  12  background pixel.
  game_over  in  1  one-cycle pulse that ends the game.
  winner  in  2  outcome, sampled with game_over: 01 = P1, 10 = P2, 11 = draw, 00 = ignore.
  restart  in  1  one-cycle pulse that clears the screen.
  addr_p1, addr_p2  out  13  ROM addresses for the player banners.
  addr_dr  out  14  ROM address for the draw banner.
  rgb_p1, rgb_p2, rgb_draw  in  12 each  ROM data, valid 1 clk after the address.
  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  same widths as inputs  delayed and mixed video.
  showing  out  1  high while the FSM is in SHOW.

Function
REQ-003 Frame start (fs) SHALL be the cycle in which hcount_in==0 and vcount_in==0.
REQ-004 FSM states SHALL be IDLE, ARMED and SHOW.
REQ-005 IDLE -> ARMED SHALL occur on game_over with winner!=00; the block latches winner into win_q.
REQ-006 A game_over with winner==00 SHALL be ignored.
REQ-007 ARMED -> SHOW SHALL occur on the next fs; frame_cnt clears to 0 on that fs.
REQ-008 restart SHALL set a pending flag in ARMED or SHOW.
REQ-009 From ARMED or SHOW, the state SHALL go to IDLE on the next fs while the pending flag is set; the pending flag and win_q clear.
REQ-010 game_over asserted in ARMED or SHOW SHALL be ignored; win_q does not change mid-display.
REQ-011 If game_over and restart are asserted in the same cycle, restart SHALL win: IDLE stays IDLE, and any other state sets the pending flag.
REQ-012 frame_cnt (8 bit) SHALL increment on each fs in SHOW and wrap 255 -> 0.
REQ-013 Stage 1 (edge N) SHALL compute addresses and the in-window flags:
  in_p = (PX <= h < PX+200) && (PY <= v < PY+34); addr_p1 = addr_p2 = (v-PY)*200 + (h-PX).
  in_d = (DX <= h < DX+201) && (DY <= v < DY+56); addr_dr = (v-DY)*201 + (h-DX).
REQ-014 Outside its window, each address SHALL be 0; products SHALL be computed with no truncation before the final width.
REQ-015 At edge N+1, the ROM SHALL return data while the block delays all video inputs and flags by a matching stage.
REQ-016 Stage 3 (edge N+2) SHALL register the outputs.
REQ-017 rgb_out SHALL equal the selected ROM pixel when all of the following hold; otherwise it equals the delayed rgb_in:
  state is SHOW;
  frame_cnt[BLINK_BIT]==0;
  the flag for win_q is set (P1/P2 use in_p, draw uses in_d);
  the pixel is not KEY.
REQ-018 Total latency from any video input to its output SHALL be 3 register stages, identical for all timing signals and rgb.
REQ-019 Timing outputs SHALL never be altered, only delayed.
REQ-020 showing SHALL be registered and SHALL rise on the same fs edge as the SHOW entry.

Reset
REQ-021 rst_n low SHALL immediately clear the following, without waiting for clk:
  state = IDLE, win_q = 00, pending = 0, frame_cnt = 0, showing = 0;
  all addresses = 0;
  all pipeline registers and video outputs = 0.
REQ-022 Reset asserted mid-SHOW SHALL blank the banner on the first post-reset pixel; after release, the FSM waits for a new game_over.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
  a) Pass-through in IDLE: rgb_in = 12'h123 at (10,10) -> rgb_out = 12'h123 three clocks later; sync and blank outputs are delayed copies.
  b) Winner P1: game_over with winner=01 mid-frame -> showing rises at the next fs.
     Pixel (300,283) -> addr_p1 = 0 one clock later; ROM data 12'hABC appears on rgb_out.
     Pixel (499,316) -> addr_p1 = 6799.
  c) Draw plus key: winner=11 -> pixel (500,327) gives addr_dr = 11255.
     ROM data = 12'hF0F -> background shown.
     Pixel (299,272) -> addr_dr = 0 and background shown (out of window).
  d) Blink: during SHOW frames 0-31 the banner is drawn, frames 32-63 it is hidden, frame 64 it is drawn again.
  e) Simultaneous game_over and restart in IDLE -> stays IDLE.
     restart during SHOW -> banner persists to the end of the current frame; IDLE and showing = 0 at the next fs.
  f) rst_n pulsed low mid-banner for 3 clocks -> rgb_out = 0 and showing = 0 asynchronously.
     After release, a pixel in the banner window shows background.
